peak_interp_sched: RTL and testbench
====================================

PEAK_INTERP_SCHED -- requirements
Module: peak_interp_sched

Interface
REQ-001 SHALL have parameter NPEAKS, default 4: number of peak slots (2..16).
REQ-002 SHALL have parameter BIN_WIDTH, default 10: FFT bin width in kHz.
REQ-003 SHALL have port clk, input, 1: sole clock, all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port load_valid, input, 1: write one peak slot this cycle.
REQ-006 SHALL have port load_idx, input, $clog2(NPEAKS): slot written.
REQ-007 SHALL have port load_bin, input, 16: peak bin index (integer).
REQ-008 SHALL have ports load_m0, load_m1, load_m2, input, 32 each: magnitudes of bins bin-1, bin, bin+1 (FP, 8 fractional bits).
REQ-009 SHALL have port start, input, 1: one-cycle pulse; begins processing of all slots.
REQ-010 SHALL have port busy, output, 1: high from accepted start until the last output is accepted.
REQ-011 SHALL have ports div_req (output, 1), div_num (output, 32), div_den (output, 32): request to the shared signed divider.
REQ-012 SHALL have ports div_ack (input, 1), div_quot (input, 32): one-cycle divider completion and signed quotient.
REQ-013 SHALL have ports source_valid, source_sop, source_eop (output, 1 each), source_ready (input, 1).
REQ-014 SHALL have ports source_freq, source_mag (output, 32 each): interpolated frequency (kHz, FP) and peak magnitude (FP).

Function
REQ-015 SHALL store slots in a register file; load_valid writes a slot only while busy=0; loads while busy=1 are ignored.
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT, EMIT; reset and completion return to IDLE.
REQ-017 IDLE: start=1 -> ISSUE with slot counter k=0, busy=1 next cycle; start while busy=1 is ignored.
REQ-018 ISSUE: compute den = 2*m1-m0-m2 and num = (m2-m0) <<< 7 for slot k (32-bit signed, wrap on overflow).
REQ-019 ISSUE with den <= 0: delta = 0, no divider request, go to EMIT next cycle.
REQ-020 ISSUE with den > 0: assert div_req with div_num/div_den, go to WAIT.
REQ-021 WAIT: div_req, div_num and div_den SHALL hold stable until div_ack; on div_ack, drop div_req the following cycle, latch delta = div_quot, go to EMIT.
REQ-022 Delta SHALL be clamped to [-128, +128] (+/-0.5 bin) before use.
REQ-023 EMIT: source_freq = ((bin <<< 8) + delta) * BIN_WIDTH; source_mag = m1 of slot k; source_sop = (k==0); source_eop = (k==NPEAKS-1); source_valid=1.
REQ-024 Output fields SHALL hold stable while source_valid=1 and source_ready=0.
REQ-025 On source_valid & source_ready: k==NPEAKS-1 -> IDLE, busy=0, source_valid=0 next cycle; else k+1 -> ISSUE.
REQ-026 Minimum latency per slot with den<=0 and source_ready=1: 2 cycles (ISSUE, EMIT).
REQ-027 At most one outstanding divider request; div_ack outside WAIT SHALL be ignored.
REQ-028 Slots SHALL be processed and emitted strictly in index order 0..NPEAKS-1.

Reset
REQ-029 reset=1 SHALL set state IDLE, k=0, busy=0, div_req=0, source_valid/sop/eop=0, source_freq/mag=0, all slot registers 0.
REQ-030 reset mid-operation SHALL abort immediately (div_req drops next cycle, no further outputs); a late div_ack after reset SHALL be ignored.
REQ-031 reset SHALL take priority over start, load_valid and div_ack in the same cycle.

Verification
REQ-032 Slot0 bin=200, m0=m2=0x100, m1=0x200, start, div_ack quot=0 after 3 cycles -> freq=2000<<8=512000, mag=0x200, sop=1.
REQ-033 Slot bin=400, m0=0, m1=0x200, m2=0x200 (den=0x200, num=0x10000) -> div_num=0x10000, div_den=0x200; quot=128 -> freq=(102400+128)*10=1025280.
REQ-034 Slot with m0=m1=m2=0x100 (den=0) -> no div_req, freq=bin*2560, emitted 2 cycles after ISSUE.
REQ-035 div_quot=500 -> clamped to 128; div_quot=-500 -> clamped to -128.
REQ-036 source_ready held low 5 cycles during EMIT -> outputs unchanged; eop only on slot 3; busy falls after final handshake.
REQ-037 reset asserted in WAIT, then div_ack -> div_req=0, busy=0, source_valid never asserted.

Source files
------------

// File: rtl/peak_interp_sched.sv
// rtl/peak_interp_sched.sv - peak slot register file with parabolic-interpolation scheduler
// Slots are interpolated in index order via a shared divider and streamed out one per handshake.
module peak_interp_sched #(
  parameter int NPEAKS    = 4,
  parameter int BIN_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_valid,
  input  logic [$clog2(NPEAKS)-1:0] load_idx,
  input  logic [15:0]               load_bin,
  input  logic [31:0]               load_m0,
  input  logic [31:0]               load_m1,
  input  logic [31:0]               load_m2,
  input  logic                      start,
  output logic                      busy,
  output logic                      div_req,
  output logic [31:0]               div_num,
  output logic [31:0]               div_den,
  input  logic                      div_ack,
  input  logic [31:0]               div_quot,
  output logic                      source_valid,
  output logic                      source_sop,
  output logic                      source_eop,
  input  logic                      source_ready,
  output logic [31:0]               source_freq,
  output logic [31:0]               source_mag
);

  localparam int IW = $clog2(NPEAKS);
  localparam logic [IW-1:0] LAST = IW'(NPEAKS - 1);
  localparam logic signed [31:0] BW = 32'(BIN_WIDTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EMIT} state_t;

  state_t state, state_next;
  logic [IW-1:0] k;

  logic [15:0]        slot_bin [NPEAKS];
  logic signed [31:0] slot_m0  [NPEAKS];
  logic signed [31:0] slot_m1  [NPEAKS];
  logic signed [31:0] slot_m2  [NPEAKS];

  logic signed [31:0] den_k, num_k, emit_delta, emit_freq;
  logic den_pos, emit_load, handshake;

  // Quotient is in 1/256-bin units; limit the correction to half a bin either way.
  function automatic logic signed [31:0] clamp_delta(input logic signed [31:0] q);
    if (q > 32'sd128) return 32'sd128;
    else if (q < -32'sd128) return -32'sd128;
    else return q;
  endfunction

  assign den_k      = (slot_m1[k] <<< 1) - slot_m0[k] - slot_m2[k];
  assign num_k      = (slot_m2[k] - slot_m0[k]) <<< 7;
  assign den_pos    = den_k > 0;
  assign handshake  = (state == EMIT) && source_ready;
  assign emit_load  = ((state == ISSUE) && !den_pos) || ((state == WAIT) && div_ack);
  assign emit_delta = (state == WAIT) ? clamp_delta($signed(div_quot)) : 32'sd0;
  assign emit_freq  = ($signed({8'd0, slot_bin[k], 8'd0}) + emit_delta) * BW;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = ISSUE;
      ISSUE: state_next = den_pos ? WAIT : EMIT;
      WAIT:  if (div_ack) state_next = EMIT;
      EMIT:  if (source_ready) state_next = (k == LAST) ? IDLE : ISSUE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k            <= '0;
      div_req      <= 1'b0;
      div_num      <= '0;
      div_den      <= '0;
      source_valid <= 1'b0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
      source_freq  <= '0;
      source_mag   <= '0;
      for (int i = 0; i < NPEAKS; i++) begin
        slot_bin[i] <= '0;
        slot_m0[i]  <= '0;
        slot_m1[i]  <= '0;
        slot_m2[i]  <= '0;
      end
    end else begin
      if (!busy && load_valid) begin
        slot_bin[load_idx] <= load_bin;
        slot_m0[load_idx]  <= load_m0;
        slot_m1[load_idx]  <= load_m1;
        slot_m2[load_idx]  <= load_m2;
      end
      if ((state == IDLE) && start) k <= '0;
      if ((state == ISSUE) && den_pos) begin
        div_req <= 1'b1;
        div_num <= num_k;
        div_den <= den_k;
      end
      if ((state == WAIT) && div_ack) div_req <= 1'b0;
      if (emit_load) begin
        source_valid <= 1'b1;
        source_freq  <= emit_freq;
        source_mag   <= slot_m1[k];
        source_sop   <= (k == '0);
        source_eop   <= (k == LAST);
      end else if (handshake) begin
        source_valid <= 1'b0;
        source_sop   <= 1'b0;
        source_eop   <= 1'b0;
        if (k != LAST) k <= k + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_peak_interp_sched.sv
// tb/tb_peak_interp_sched.sv - scoreboard bench for peak_interp_sched
// Expected outputs and divider operations are queued at start; monitors pop and compare.
module tb_peak_interp_sched;
  localparam int NPEAKS = 4;
  localparam int BIN_WIDTH = 10;
  localparam int IW = $clog2(NPEAKS);

  logic clk, reset, load_valid, start, busy, div_req, div_ack;
  logic [IW-1:0] load_idx;
  logic [15:0] load_bin;
  logic [31:0] load_m0, load_m1, load_m2, div_num, div_den, div_quot;
  logic source_valid, source_sop, source_eop, source_ready;
  logic [31:0] source_freq, source_mag;

  peak_interp_sched #(.NPEAKS(NPEAKS), .BIN_WIDTH(BIN_WIDTH)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_idx(load_idx),
    .load_bin(load_bin), .load_m0(load_m0), .load_m1(load_m1), .load_m2(load_m2),
    .start(start), .busy(busy), .div_req(div_req), .div_num(div_num), .div_den(div_den),
    .div_ack(div_ack), .div_quot(div_quot), .source_valid(source_valid),
    .source_sop(source_sop), .source_eop(source_eop), .source_ready(source_ready),
    .source_freq(source_freq), .source_mag(source_mag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int freq; int mag; bit sop; bit eop; } exp_t;
  typedef struct { int num; int den; int quot; } divop_t;

  int n_checks = 0;
  int n_errors = 0;
  exp_t exp_q[$];
  divop_t div_q[$];
  int mdl_bin[NPEAKS], mdl_m0[NPEAKS], mdl_m1[NPEAKS], mdl_m2[NPEAKS];
  int plan_quot[NPEAKS];
  bit plan_set[NPEAKS];
  bit auto_div = 1'b1;
  int ready_pct = 70;
  bit stall_on_valid = 1'b0;
  int ready_low = 0;
  int manual_req = 0;
  int manual_seen = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  function automatic int clampq(input int q);
    return (q > 128) ? 128 : ((q < -128) ? -128 : q);
  endfunction

  // Reference: parabolic peak interpolation applied to each slot in order.
  task automatic plan_frame();
    for (int s = 0; s < NPEAKS; s++) begin
      int den, num, q, delta;
      den = 2 * mdl_m1[s] - mdl_m0[s] - mdl_m2[s];
      num = (mdl_m2[s] - mdl_m0[s]) * 128;
      delta = 0;
      if (den > 0) begin
        if (plan_set[s]) q = plan_quot[s];
        else if ($urandom_range(0, 3) == 0) q = int'($urandom_range(0, 1200)) - 600;
        else q = num / den;
        div_q.push_back('{num, den, q});
        delta = clampq(q);
      end
      plan_set[s] = 1'b0;
      exp_q.push_back('{(mdl_bin[s] * 256 + delta) * BIN_WIDTH, mdl_m1[s], s == 0, s == NPEAKS - 1});
    end
  endtask

  // Output monitor: drives ready, checks hold-while-stalled and pops the scoreboard.
  exp_t mon_e;
  bit prev_stall = 1'b0;
  logic [31:0] hold_freq, hold_mag;
  logic hold_sop, hold_eop;
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
      source_ready = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", source_valid, 1);
        chk("hold_freq", source_freq, hold_freq);
        chk("hold_mag", source_mag, hold_mag);
        chk("hold_sop", source_sop, hold_sop);
        chk("hold_eop", source_eop, hold_eop);
      end
      if (stall_on_valid && source_valid) begin
        ready_low = 5;
        stall_on_valid = 1'b0;
      end
      if (ready_low > 0) begin
        source_ready = 1'b0;
        ready_low--;
      end else begin
        source_ready = (int'($urandom_range(0, 99)) < ready_pct);
      end
      if (source_valid && source_ready) begin
        chk("output_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("freq", $signed(source_freq), mon_e.freq);
          chk("mag", $signed(source_mag), mon_e.mag);
          chk("sop", source_sop, mon_e.sop);
          chk("eop", source_eop, mon_e.eop);
        end
      end
      prev_stall = source_valid && !source_ready;
      hold_freq = source_freq;
      hold_mag = source_mag;
      hold_sop = source_sop;
      hold_eop = source_eop;
    end
  end

  // Divider responder with random latency; also throws stray acks outside WAIT.
  divop_t cur_div;
  bit in_req = 1'b0;
  int lat = 0;
  logic [31:0] hold_num, hold_den;
  always @(negedge clk) begin
    div_ack = 1'b0;
    if (manual_req != manual_seen) begin
      manual_seen = manual_req;
      div_ack = 1'b1;
      div_quot = 32'd0;
    end else if (reset || !auto_div) begin
      in_req = 1'b0;
    end else if (div_req) begin
      if (!in_req) begin
        chk("div_planned", div_q.size() > 0, 1);
        if (div_q.size() > 0) begin
          cur_div = div_q.pop_front();
          chk("div_num", $signed(div_num), cur_div.num);
          chk("div_den", $signed(div_den), cur_div.den);
        end else begin
          cur_div = '{0, 0, 0};
        end
        in_req = 1'b1;
        lat = int'($urandom_range(0, 4));
        hold_num = div_num;
        hold_den = div_den;
      end else begin
        chk("div_num_stable", div_num, hold_num);
        chk("div_den_stable", div_den, hold_den);
      end
      if (lat == 0) begin
        div_ack = 1'b1;
        div_quot = cur_div.quot;
        in_req = 1'b0;
      end else begin
        lat--;
      end
    end else if (in_req) begin
      chk("div_req_held", div_req, 1);
      in_req = 1'b0;
    end else if ($urandom_range(0, 9) == 0) begin
      div_ack = 1'b1;
      div_quot = $urandom;
    end
  end

  task automatic load(input int idx, input int bin, input int m0, input int m1, input int m2);
    bit b;
    @(posedge clk); #1;
    b = busy;
    load_valid = 1'b1;
    load_idx = IW'(idx);
    load_bin = 16'(bin);
    load_m0 = m0;
    load_m1 = m1;
    load_m2 = m2;
    @(posedge clk); #1;
    load_valid = 1'b0;
    if (!b) begin
      mdl_bin[idx] = bin;
      mdl_m0[idx] = m0;
      mdl_m1[idx] = m1;
      mdl_m2[idx] = m2;
    end
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic do_reset(input bit with_traffic);
    @(posedge clk); #1;
    reset = 1'b1;
    start = with_traffic;
    load_valid = with_traffic;
    load_idx = '0;
    load_bin = 16'd123;
    load_m0 = 32'h300;
    load_m1 = 32'h500;
    load_m2 = 32'h100;
    exp_q.delete();
    div_q.delete();
    for (int s = 0; s < NPEAKS; s++) begin
      mdl_bin[s] = 0; mdl_m0[s] = 0; mdl_m1[s] = 0; mdl_m2[s] = 0; plan_set[s] = 1'b0;
    end
    @(posedge clk); #1;
    start = 1'b0;
    load_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic run_frame(input bit measure, input bit poke);
    int cnt;
    cnt = 0;
    plan_frame();
    do_start();
    if (poke) begin
      load($urandom_range(0, NPEAKS - 1), $urandom_range(0, 65535), $urandom_range(0, 32'h30000),
           $urandom_range(0, 32'h30000), $urandom_range(0, 32'h30000));
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    for (int c = 0; c < 5000 && busy; c++) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    chk("busy_done", busy, 0);
    if (measure) chk("latency", cnt, 2 * NPEAKS);
    chk("exp_drained", exp_q.size(), 0);
    chk("div_drained", div_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; load_valid = 1'b0; load_idx = '0; load_bin = '0;
    load_m0 = '0; load_m1 = '0; load_m2 = '0; div_quot = '0; div_ack = 1'b0; source_ready = 1'b0;
    do_reset(1'b1);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_div_req", div_req, 0);
    chk("rst_valid", source_valid, 0);
    chk("rst_sop", source_sop, 0);
    chk("rst_eop", source_eop, 0);
    chk("rst_freq", source_freq, 0);
    chk("rst_mag", source_mag, 0);

    run_frame(1'b0, 1'b0);

    load(0, 200, 32'h100, 32'h200, 32'h100); plan_set[0] = 1'b1; plan_quot[0] = 0;
    load(1, 400, 0, 32'h200, 32'h200);       plan_set[1] = 1'b1; plan_quot[1] = 128;
    load(2, 300, 32'h100, 32'h100, 32'h100);
    load(3, 50, 32'h100, 32'h200, 32'h100);  plan_set[3] = 1'b1; plan_quot[3] = 500;
    stall_on_valid = 1'b1;
    run_frame(1'b0, 1'b0);

    plan_set[0] = 1'b1; plan_quot[0] = -500;
    run_frame(1'b0, 1'b0);

    for (int s = 0; s < NPEAKS; s++) load(s, 1000 + s, 32'h100 * s, 32'h100 * s, 32'h100 * s);
    ready_pct = 100;
    run_frame(1'b1, 1'b0);

    for (int f = 0; f < 20; f++) begin
      for (int s = 0; s < NPEAKS; s++)
        if ($urandom_range(0, 1) == 1)
          load(s, $urandom_range(0, 65535), $urandom_range(0, 32'h30000),
               $urandom_range(0, 32'h30000), $urandom_range(0, 32'h30000));
      ready_pct = int'($urandom_range(30, 100));
      run_frame(1'b0, 1'b1);
    end

    ready_pct = 70;
    auto_div = 1'b0;
    load(0, 200, 32'h100, 32'h200, 32'h100);
    do_start();
    for (int c = 0; c < 20 && !div_req; c++) @(negedge clk);
    chk("abort_div_req_seen", div_req, 1);
    repeat (2) @(negedge clk);
    do_reset(1'b1);
    manual_req++;
    repeat (6) @(negedge clk);
    chk("abort_div_req", div_req, 0);
    chk("abort_busy", busy, 0);
    chk("abort_valid", source_valid, 0);
    auto_div = 1'b1;

    run_frame(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
